// File: rtl/m_memarb.sv
// ----------------------------------------------------------------------------
// m_memarb -- two-port arbiter in front of one single-ported, synchronous-read
// word memory. Port 0 is the instruction-fetch reader, port 1 the data-access
// reader/writer. Grants are combinational in the request cycle and read data
// returns one cycle later on w_rdata, tagged by r_vld0 / r_vld1.
//
// Conflict policy:
//   default         : port 1 wins, except when port 0 has been refused
//                     MAX_WAIT consecutive cycles (aging counter r_wait).
//   MEMARB_RR_EN    : define this macro for round-robin on conflicts, using
//                     r_last (last granted port); no aging counter then.
//
// Ports:
//   w_clk, w_rst_n          clock, asynchronous active-low reset
//   w_req0, w_addr0         port 0 read request and word address
//   w_req1, w_we1, w_addr1,
//   w_din1                  port 1 request, write enable, address, write data
//   w_gnt0, w_gnt1          combinational grants (deasserted grant = stall)
//   r_vld0, r_vld1          w_rdata carries read data for port 0 / port 1
//   w_rdata                 read data (memory output passed through)
//   w_mem_addr, w_mem_we,
//   w_mem_din, w_mem_dout   memory-side interface (1-cycle read latency)
//   r_conf                  saturating count of cycles with both requesting
// ----------------------------------------------------------------------------
module m_memarb #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_req0,
  input  logic [ADDR_W-1:0] w_addr0,
  input  logic              w_req1,
  input  logic              w_we1,
  input  logic [ADDR_W-1:0] w_addr1,
  input  logic [DATA_W-1:0] w_din1,
  output logic              w_gnt0,
  output logic              w_gnt1,
  output logic              r_vld0,
  output logic              r_vld1,
  output logic [DATA_W-1:0] w_rdata,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic              w_mem_we,
  output logic [DATA_W-1:0] w_mem_din,
  input  logic [DATA_W-1:0] w_mem_dout,
  output logic [15:0]       r_conf
);

`ifdef MEMARB_RR_EN
  // Last granted port: 0 = port 0, 1 = port 1. Reset value 0 hands the first
  // conflict to port 1.
  logic r_last;

  // A conflict goes to the port that was not granted last.
  assign w_gnt0 = w_req0 & (~w_req1 | r_last);
  assign w_gnt1 = w_req1 & ~w_gnt0;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_last <= 1'b0;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
    end
  end
  // No aging counter in this mode: round-robin already bounds starvation.
`else
  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  // Consecutive cycles port 0 has been requesting without a grant.
  logic [3:0] r_wait;

  // Port 1 has priority until port 0 has aged out.
  assign w_gnt0 = w_req0 & (~w_req1 | (r_wait == MAX_WAIT_L));
  assign w_gnt1 = w_req1 & ~w_gnt0;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wait <= 4'd0;
    end else if (w_req0 && !w_gnt0) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // the pre-edge values; blocking (=) here would create order races.
      if (r_wait != MAX_WAIT_L) r_wait <= r_wait + 4'd1;
    end else begin
      r_wait <= 4'd0;
    end
  end
`endif

  // Memory drive: port 1 address when granted, otherwise port 0 (also idle).
  // The write strobe is gated by reset so nothing is written while in reset.
  assign w_mem_addr = w_gnt1 ? w_addr1 : w_addr0;
  assign w_mem_we   = w_gnt1 & w_we1 & w_rst_n;
  assign w_mem_din  = w_din1;
  assign w_rdata    = w_mem_dout;

  // Valids trail the grant by the memory's one-cycle read latency. The
  // asynchronous clear also cancels a valid for a read granted just before
  // reset.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
    end else begin
      r_vld0 <= w_gnt0;
      r_vld1 <= w_gnt1 & ~w_we1;
    end
  end

  // Saturating conflict counter.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_conf <= 16'd0;
    end else if (w_req0 && w_req1 && (r_conf != 16'hFFFF)) begin
      r_conf <= r_conf + 16'd1;
    end
  end

endmodule

// File: doc/m_memarb.md
# m_memarb

Two-port arbiter that shares one single-ported, synchronous-read word memory between the pipeline's instruction-fetch requester (port 0, read-only) and its data-access requester (port 1, read/write), so the processor can run from a unified instruction/data memory. Grants are issued combinationally in the request cycle, with read data returned one cycle later. Conflicts go to port 1 (the older in-flight instruction), and an aging counter bounds port 0 starvation. The block sits between the IF/MEM stages and one memory instance; the losing stage uses the deasserted grant as its stall.

## Interface
Parameters:
- ADDR_W, 12, word address width (4K words)
- DATA_W, 32, data width
- MAX_WAIT, 4, maximum consecutive cycles port 0 may be denied while requesting (1..15)

Ports:
- w_clk  in  1  clock, all state on rising edge
- w_rst_n  in  1  reset, asynchronous, active-low
- w_req0  in  1  port 0 read request (level, held until granted)
- w_addr0  in  ADDR_W  port 0 word address
- w_req1  in  1  port 1 request (level, held until granted)
- w_we1  in  1  port 1 write enable (1 = write, 0 = read)
- w_addr1  in  ADDR_W  port 1 word address
- w_din1  in  DATA_W  port 1 write data
- w_gnt0  out  1  port 0 granted this cycle (combinational)
- w_gnt1  out  1  port 1 granted this cycle (combinational)
- r_vld0  out  1  w_rdata holds port 0 read data
- r_vld1  out  1  w_rdata holds port 1 read data (never set for writes)
- w_rdata  out  DATA_W  read data, equal to w_mem_dout
- w_mem_addr  out  ADDR_W  memory address
- w_mem_we  out  1  memory write enable
- w_mem_din  out  DATA_W  memory write data (= w_din1)
- w_mem_dout  in  DATA_W  memory registered read data (1-cycle latency, read-before-write)
- r_conf  out  16  conflict counter

## Operation
- Only one requester active: it is granted in the same cycle.
- Both requesting: port 1 wins unless r_wait == MAX_WAIT, in which case port 0 wins.
- r_wait (4 bit):
  - increments when w_req0 & ~w_gnt0, saturating at MAX_WAIT;
  - clears when w_gnt0 or ~w_req0.
- Memory drive:
  - w_mem_addr = w_gnt1 ? w_addr1 : w_addr0;
  - w_mem_we = w_gnt1 & w_we1;
  - idle cycles drive w_addr0 with we = 0.
- Valids: r_vld0 <= w_gnt0; r_vld1 <= w_gnt1 & ~w_we1.
- r_conf increments each cycle with w_req0 & w_req1, saturating at 16'hFFFF.
- Requesters must hold their address, data and we stable while req is high and gnt is low. Changing them while ungranted is undefined.
- Reset (w_rst_n low, any time):
  - r_wait, r_vld0, r_vld1, r_conf, r_last all clear to 0 immediately;
  - a read granted in the cycle before reset yields no valid;
  - grants stay combinational on the request inputs during reset, but w_mem_we is forced to 0 while w_rst_n is low.

## Timing
- Grant latency is 0 cycles. Read data and valid arrive exactly 1 cycle after the grant.
- Writes take effect at the grant cycle's rising edge.
- A new grant may be issued every cycle. Back-to-back reads from the same port return data on consecutive cycles.
- Port 0 worst-case latency under continuous port 1 traffic: denied MAX_WAIT cycles, then granted on cycle MAX_WAIT+1.
- Port 1 worst case in default mode: denied one cycle per aging win.
- Output reset values: r_vld0 = 0, r_vld1 = 0, r_conf = 0. Combinational outputs follow the inputs.

## Configuration
- MEMARB_RR_EN defined: conflicts are resolved round-robin.
  - 1-bit r_last records the last granted port (reset 0, so port 1 wins the first conflict).
  - A conflict goes to the port other than r_last, and r_last updates on every grant.
  - r_wait is held at 0 and MAX_WAIT is unused.
- MEMARB_RR_EN undefined: fixed port 1 priority with port 0 aging as described above. r_last is not implemented.

## Test plan
- Reset: drive w_rst_n low mid-run with both reqs high -> r_vld0 = r_vld1 = 0, r_conf = 0, w_mem_we = 0 until release.
- Port 0 alone, address 5, memory word 5 = 32'h00000020 -> w_gnt0 = 1 the same cycle, r_vld0 = 1 the next cycle with w_rdata = 32'h20, r_conf remains 0.
- Port 1 writes 32'hDEADBEEF to address 3, then reads address 3 -> one w_mem_we pulse; r_vld1 low after the write and high 1 cycle after the read grant; w_rdata = 32'hDEADBEEF.
- Both requesting continuously, MAX_WAIT = 4, default build -> grant sequence 1,1,1,1,0,1,1,1,1,0,... (port number); r_conf = 10 after 10 cycles.
- Same stimulus with MEMARB_RR_EN defined -> grants alternate 1,0,1,0,...
- Port 0 granted, then w_rst_n pulsed low before the next edge -> no r_vld0 after release; first conflict after release goes to port 1.
